// File: rtl/button_conditioner.sv
// Multi-channel button front end: synchronise, polarity-correct and debounce each pin,
// then derive press/release pulses and an auto-repeat pulse stream per channel.
module button_conditioner #(
  parameter int                NUM_CH          = 4,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter int                REPEAT_DELAY    = 25000000,
  parameter int                REPEAT_PERIOD   = 5000000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW      = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_rise,
  output logic [NUM_CH-1:0] btn_fall,
  output logic [NUM_CH-1:0] btn_repeat
);

  localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW         = $clog2(DEBOUNCE_CYCLES);
  localparam int RW         = $clog2(REPEAT_MAX);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE     = DW'(1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);

  localparam logic [1:0] RELEASED    = 2'd0;
  localparam logic [1:0] HELD_DELAY  = 2'd1;
  localparam logic [1:0] HELD_REPEAT = 2'd2;

  logic [NUM_CH-1:0] raw;
  assign raw = btn_in ^ ACTIVE_LOW;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          level;
    logic          rise;
    logic          fall;
    logic          rep;
    logic [DW-1:0] db_cnt;
    logic [1:0]    state;
    logic [RW-1:0] rep_cnt;
    logic          accept;
    logic          accept_press;
    logic          accept_release;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    assign accept         = (s2 != level) && (db_cnt == DB_LAST);
    assign accept_press   = accept && !level;
    assign accept_release = accept && level;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        level  <= 1'b0;
        rise   <= 1'b0;
        fall   <= 1'b0;
        db_cnt <= '0;
      end else begin
        s1   <= raw[i];
        s2   <= s1;
        rise <= accept_press;
        fall <= accept_release;
        if (s2 == level) begin
          db_cnt <= '0;
        end else if (accept) begin
          level  <= ~level;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_ONE;
        end
      end
    end

    // Release always wins over a coinciding repeat tick; repeat_en only gates the pulse.
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= RELEASED;
        rep_cnt <= '0;
        rep     <= 1'b0;
      end else begin
        rep <= 1'b0;
        case (state)
          RELEASED: begin
            rep_cnt <= '0;
            if (accept_press) begin
              state <= HELD_DELAY;
              rep   <= 1'b1;
            end else begin
              state <= RELEASED;
            end
          end
          HELD_DELAY: begin
            if (accept_release) begin
              state   <= RELEASED;
              rep_cnt <= '0;
            end else if (rep_cnt == DELAY_LAST) begin
              state   <= HELD_REPEAT;
              rep_cnt <= '0;
              rep     <= repeat_en[i];
            end else begin
              rep_cnt <= rep_cnt + REP_ONE;
            end
          end
          HELD_REPEAT: begin
            if (accept_release) begin
              state   <= RELEASED;
              rep_cnt <= '0;
            end else if (rep_cnt == PERIOD_LAST) begin
              rep_cnt <= '0;
              rep     <= repeat_en[i];
            end else begin
              rep_cnt <= rep_cnt + REP_ONE;
            end
          end
          default: begin
            state   <= RELEASED;
            rep_cnt <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]  = level;
    assign btn_rise[i]   = rise;
    assign btn_fall[i]   = fall;
    assign btn_repeat[i] = rep;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, channel 1 active-low.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] repeat_en;
  logic [3:0] btn_level;
  logic [3:0] btn_rise;
  logic [3:0] btn_fall;
  logic [3:0] btn_repeat;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(
    .NUM_CH         (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .ACTIVE_LOW     (4'b0010)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic [3:0] observed,
                       input logic [3:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s@%0d: observed=%b expected=%b", tag, k, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input int k, input logic [3:0] e_level,
                           input logic [3:0] e_rise, input logic [3:0] e_fall,
                           input logic [3:0] e_rep);
    check({tag, "_level"}, k, btn_level, e_level);
    check({tag, "_rise"}, k, btn_rise, e_rise);
    check({tag, "_fall"}, k, btn_fall, e_fall);
    check({tag, "_repeat"}, k, btn_repeat, e_rep);
  endtask

  initial begin
    logic [3:0] e_rep;

    // Reset with all buttons released (ch1 idles high because it is active-low).
    reset     = 1'b1;
    btn_in    = 4'b0010;
    repeat_en = 4'b1111;
    repeat (3) tick();
    check_all("reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("idle", k, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // Clean press on ch0: accepted at edge 5, repeats at 15, 18, 21.
    btn_in = 4'b0011;
    for (int k = 0; k < 23; k++) begin
      tick();
      e_rep = {3'b000, (k == 5 || k == 15 || k == 18 || k == 21)};
      check_all("press", k, (k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000,
                4'b0000, e_rep);
    end

    // Release from HELD_REPEAT: ticks still fire until the release is accepted at r=5.
    btn_in = 4'b0010;
    for (int r = 0; r < 8; r++) begin
      tick();
      e_rep = {3'b000, (r == 1 || r == 4)};
      check_all("rel_rep", r, (r < 5) ? 4'b0001 : 4'b0000, 4'b0000,
                (r == 5) ? 4'b0001 : 4'b0000, e_rep);
    end

    // Bounce on ch0: 1,0,1,0 for two cycles each, then held; single press at edge 13.
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || k == 4 || k == 8) btn_in = 4'b0011;
      if (k == 2 || k == 6) btn_in = 4'b0010;
      tick();
      check_all("bounce", k, (k >= 13) ? 4'b0001 : 4'b0000, (k == 13) ? 4'b0001 : 4'b0000,
                4'b0000, (k == 13) ? 4'b0001 : 4'b0000);
    end

    // Release during HELD_DELAY: fall at edge 21, and no repeat at the would-be edge 23.
    btn_in = 4'b0010;
    for (int k = 16; k < 27; k++) begin
      tick();
      check_all("rel_delay", k, (k < 21) ? 4'b0001 : 4'b0000, 4'b0000,
                (k == 21) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    // Simultaneous press ch0 + active-low ch1; ch1 repeat disabled until edge 20.
    repeat_en = 4'b1101;
    btn_in    = 4'b0001;
    for (int k = 0; k < 26; k++) begin
      if (k == 20) repeat_en = 4'b1111;
      tick();
      e_rep[0] = (k == 5 || k == 15 || k == 18 || k == 21 || k == 24);
      e_rep[1] = (k == 5 || k == 21 || k == 24);
      e_rep[3:2] = 2'b00;
      check_all("dual", k, (k >= 5) ? 4'b0011 : 4'b0000, (k == 5) ? 4'b0011 : 4'b0000,
                4'b0000, e_rep);
    end

    btn_in = 4'b0010;
    for (int r = 0; r < 8; r++) begin
      tick();
      check_all("dual_rel", r, (r < 5) ? 4'b0011 : 4'b0000, 4'b0000,
                (r == 5) ? 4'b0011 : 4'b0000, (r == 1 || r == 4) ? 4'b0011 : 4'b0000);
    end

    // ch2 into HELD_REPEAT, then a one-cycle reset while it is still held.
    btn_in = 4'b0110;
    for (int k = 0; k < 17; k++) begin
      tick();
      check_all("ch2", k, (k >= 5) ? 4'b0100 : 4'b0000, (k == 5) ? 4'b0100 : 4'b0000,
                4'b0000, (k == 5 || k == 15) ? 4'b0100 : 4'b0000);
    end

    reset = 1'b1;
    tick();
    check_all("mid_reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check_all("re_press", j, (j >= 5) ? 4'b0100 : 4'b0000, (j == 5) ? 4'b0100 : 4'b0000,
                4'b0000, (j == 5) ? 4'b0100 : 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
